// File: rtl/top_system_pkg.sv
// ============================================================================
// Module   : top_system_pkg
// Purpose  : Shared constants, default parameters and FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package top_system_pkg;

    localparam int KERNEL_SIZE            = 3;

    localparam int DEF_IO_DATA_WIDTH      = 16;
    localparam int DEF_ACCUMULATION_WIDTH = 16;
    localparam int DEF_FEATURE_MAP_WIDTH  = 128;
    localparam int DEF_FEATURE_MAP_HEIGHT = 128;
    localparam int DEF_INPUT_NB_CHANNELS  = 2;
    localparam int DEF_OUTPUT_NB_CHANNELS = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/top_system_mac_unit.sv
// ============================================================================
// Module   : mac_unit
// Purpose  : Signed multiplier plus wrapping accumulator with clear/enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_i,
    input  logic signed [DATA_WIDTH-1:0] feature_i,
    input  logic signed [DATA_WIDTH-1:0] weight_i,
    input  logic                         acc_en_i,
    input  logic                         clear_i,
    output logic [ACC_WIDTH-1:0]         acc_o
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    logic signed [PROD_WIDTH-1:0] w_product;
    logic [ACC_WIDTH-1:0]         acc_q;
    logic [ACC_WIDTH-1:0]         acc_d;

    assign w_product = PROD_WIDTH'(feature_i) * PROD_WIDTH'(weight_i);

    // Only the low accumulator bits of the product contribute; overflow wraps.
    generate
        if (ACC_WIDTH < PROD_WIDTH) begin : g_prod_hi
            logic w_unused_prod_hi;
            assign w_unused_prod_hi = ^w_product[PROD_WIDTH-1:ACC_WIDTH];
        end
    endgenerate

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (acc_en_i) begin
            acc_d = acc_q + w_product[ACC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/top_system.sv
// ============================================================================
// Module   : top_system
// Purpose  : 3x3 convolution engine streaming features/weights over shared busses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module top_system
    import top_system_pkg::*;
#(
    parameter int IO_DATA_WIDTH      = DEF_IO_DATA_WIDTH,
    parameter int ACCUMULATION_WIDTH = DEF_ACCUMULATION_WIDTH,
    parameter int FEATURE_MAP_WIDTH  = DEF_FEATURE_MAP_WIDTH,
    parameter int FEATURE_MAP_HEIGHT = DEF_FEATURE_MAP_HEIGHT,
    parameter int INPUT_NB_CHANNELS  = DEF_INPUT_NB_CHANNELS,
    parameter int OUTPUT_NB_CHANNELS = DEF_OUTPUT_NB_CHANNELS
) (
    input  logic                                  clk,
    input  logic                                  arst_n_in,
    input  logic                                  conv_stride_mode,
    inout  wire  [IO_DATA_WIDTH-1:0]              bus_1,
    inout  wire  [IO_DATA_WIDTH-1:0]              bus_2,
    inout  wire  [IO_DATA_WIDTH-1:0]              bus_3,
    input  logic                                  bus_valid,
    output logic                                  bus_ready,
    output logic                                  driving_busses,
    output logic                                  output_valid,
    output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
    output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
    output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch,
    input  logic                                  start,
    output logic                                  running
);

    localparam int XW   = $clog2(FEATURE_MAP_WIDTH);
    localparam int YW   = $clog2(FEATURE_MAP_HEIGHT);
    localparam int CW   = $clog2(OUTPUT_NB_CHANNELS);
    localparam int TAPS = KERNEL_SIZE * KERNEL_SIZE * INPUT_NB_CHANNELS;
    localparam int TW   = $clog2(TAPS);

    localparam logic [TW-1:0] LAST_TAP = TW'(TAPS - 1);
    localparam logic [CW-1:0] LAST_CH  = CW'(OUTPUT_NB_CHANNELS - 1);
    localparam logic [XW:0]   X_LIMIT  = (XW + 1)'(FEATURE_MAP_WIDTH);
    localparam logic [YW:0]   Y_LIMIT  = (YW + 1)'(FEATURE_MAP_HEIGHT);

    state_e          state_q,  state_d;
    logic [1:0]      stride_q, stride_d;
    logic [XW-1:0]   x_q,      x_d;
    logic [YW-1:0]   y_q,      y_d;
    logic [CW-1:0]   ch_q,     ch_d;
    logic [TW-1:0]   tap_q,    tap_d;

    logic            w_start_ok;
    logic            w_xfer;
    logic            w_out_cycle;
    logic [XW:0]     w_x_sum;
    logic [YW:0]     w_y_sum;
    logic            w_x_wrap;
    logic            w_y_wrap;
    logic            w_ch_wrap;
    logic [ACCUMULATION_WIDTH-1:0] w_acc;
    logic [IO_DATA_WIDTH-1:0]      w_result;
    logic            w_unused_bus3;

    assign w_start_ok  = (state_q == ST_IDLE) && start;
    assign w_xfer      = (state_q == ST_FETCH) && bus_valid;
    assign w_out_cycle = (state_q == ST_OUTPUT);

    // Wider sums let the wrap test see a step past the map edge for either stride.
    assign w_x_sum   = {1'b0, x_q} + {{(XW - 1){1'b0}}, stride_q};
    assign w_y_sum   = {1'b0, y_q} + {{(YW - 1){1'b0}}, stride_q};
    assign w_x_wrap  = (w_x_sum >= X_LIMIT);
    assign w_y_wrap  = (w_y_sum >= Y_LIMIT);
    assign w_ch_wrap = (ch_q == LAST_CH);

    always_comb begin
        state_d  = state_q;
        stride_d = stride_q;
        x_d      = x_q;
        y_d      = y_q;
        ch_d     = ch_q;
        tap_d    = tap_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_FETCH;
                    stride_d = conv_stride_mode ? 2'd2 : 2'd1;
                    x_d      = '0;
                    y_d      = '0;
                    ch_d     = '0;
                    tap_d    = '0;
                end
            end
            ST_FETCH: begin
                if (bus_valid) begin
                    if (tap_q == LAST_TAP) begin
                        tap_d   = '0;
                        state_d = ST_OUTPUT;
                    end else begin
                        tap_d = tap_q + TW'(1);
                    end
                end
            end
            ST_OUTPUT: begin
                state_d = (w_ch_wrap && w_x_wrap && w_y_wrap) ? ST_IDLE : ST_FETCH;
                if (w_ch_wrap) begin
                    ch_d = '0;
                    if (w_x_wrap) begin
                        x_d = '0;
                        y_d = w_y_wrap ? '0 : w_y_sum[YW-1:0];
                    end else begin
                        x_d = w_x_sum[XW-1:0];
                    end
                end else begin
                    ch_d = ch_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst_n_in) begin
            state_q  <= ST_IDLE;
            stride_q <= 2'd1;
            x_q      <= '0;
            y_q      <= '0;
            ch_q     <= '0;
            tap_q    <= '0;
        end else begin
            state_q  <= state_d;
            stride_q <= stride_d;
            x_q      <= x_d;
            y_q      <= y_d;
            ch_q     <= ch_d;
            tap_q    <= tap_d;
        end
    end

    mac_unit #(
        .DATA_WIDTH (IO_DATA_WIDTH),
        .ACC_WIDTH  (ACCUMULATION_WIDTH)
    ) u_mac (
        .clk       (clk),
        .rst_i     (arst_n_in),
        .feature_i (bus_1),
        .weight_i  (bus_2),
        .acc_en_i  (w_xfer),
        .clear_i   (w_start_ok || w_out_cycle),
        .acc_o     (w_acc)
    );

    generate
        if (ACCUMULATION_WIDTH >= IO_DATA_WIDTH) begin : g_res_trunc
            assign w_result = w_acc[IO_DATA_WIDTH-1:0];
        end else begin : g_res_sext
            assign w_result = {{(IO_DATA_WIDTH - ACCUMULATION_WIDTH){w_acc[ACCUMULATION_WIDTH-1]}}, w_acc};
        end
    endgenerate

    assign bus_1 = w_out_cycle ? w_result : {IO_DATA_WIDTH{1'bz}};
    assign bus_2 = w_out_cycle ? '0       : {IO_DATA_WIDTH{1'bz}};
    assign bus_3 = w_out_cycle ? '0       : {IO_DATA_WIDTH{1'bz}};
    assign w_unused_bus3 = ^bus_3;

    assign bus_ready      = (state_q == ST_FETCH);
    assign driving_busses = w_out_cycle;
    assign output_valid   = w_out_cycle;
    assign output_x       = x_q;
    assign output_y       = y_q;
    assign output_ch      = ch_q;
    assign running        = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_top_system.sv
// ============================================================================
// Module   : tb_top_system
// Purpose  : Self-checking bench: constant-data vector table plus randomized runs vs. a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_top_system;

    localparam int W   = 4;
    localparam int H   = 4;
    localparam int NCH = 16;

    logic        clk = 1'b0;
    logic        rst, start, mode, bus_valid, tb_drv;
    logic [15:0] tb_f, tb_w, tb_b3;
    wire  [15:0] bus_1, bus_2, bus_3;
    logic        bus_ready, driving_busses, output_valid, running;
    logic [1:0]  output_x, output_y;
    logic [3:0]  output_ch;

    assign bus_1 = (tb_drv && !driving_busses) ? tb_f  : 16'bz;
    assign bus_2 = (tb_drv && !driving_busses) ? tb_w  : 16'bz;
    assign bus_3 = (tb_drv && !driving_busses) ? tb_b3 : 16'bz;

    top_system #(
        .FEATURE_MAP_WIDTH  (W),
        .FEATURE_MAP_HEIGHT (H)
    ) dut (
        .clk              (clk),
        .arst_n_in        (rst),
        .conv_stride_mode (mode),
        .bus_1            (bus_1),
        .bus_2            (bus_2),
        .bus_3            (bus_3),
        .bus_valid        (bus_valid),
        .bus_ready        (bus_ready),
        .driving_busses   (driving_busses),
        .output_valid     (output_valid),
        .output_x         (output_x),
        .output_y         (output_y),
        .output_ch        (output_ch),
        .start            (start),
        .running          (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] f;
        logic [15:0] w;
        bit          first_only;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        int          x;
        int          y;
        int          ch;
        logic [15:0] val;
    } exp_t;

    vec_t vecs[8];
    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_out = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every result cycle must match the next queued model entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && output_valid) begin
            n_out++;
            if (q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = q.pop_front();
                check("out_value", bus_1, e.val);
                check("out_x", output_x, e.x);
                check("out_y", output_y, e.y);
                check("out_ch", output_ch, e.ch);
                check("out_bus23_zero", {bus_2, bus_3}, 0);
                check("out_flags", {driving_busses, bus_ready}, 2'b10);
            end
        end
    end

    task automatic xfer(input logic [15:0] f, input logic [15:0] w);
        int gaps = $urandom_range(0, 3);
        bit done = 1'b0;
        // Garbage on the busses with bus_valid low must never be accumulated.
        repeat (gaps) begin
            @(negedge clk);
            bus_valid = 1'b0;
            tb_drv    = 1'b1;
            tb_f      = 16'($urandom);
            tb_w      = 16'($urandom);
            tb_b3     = 16'($urandom);
        end
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus_ready) begin
                tb_f      = f;
                tb_w      = w;
                tb_b3     = 16'($urandom);
                tb_drv    = 1'b1;
                bus_valid = 1'b1;
                @(posedge clk);
                #1;
                bus_valid = 1'b0;
                tb_drv    = 1'b0;
                done      = 1'b1;
            end else begin
                bus_valid = 1'b0;
            end
        end
        if (!done) check("xfer_timeout", 0, 1);
    endtask

    task automatic check_reset_state(input string name);
        check(name, {running, bus_ready, output_valid, driving_busses,
                     output_x, output_y, output_ch}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; bus_valid = 1'b0; tb_drv = 1'b0;
        @(negedge clk);
        check_reset_state("reset_state");
        rst = 1'b0;
    endtask

    task automatic start_conv(input bit s);
        @(negedge clk);
        mode  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("running_after_start", running, 1);
    endtask

    // Reference model: walks the loop nest, applies zero padding, sums products.
    task automatic run_conv(input bit s, input int limit, input bit ones, input int pulse_at);
        int step = s ? 2 : 1;
        int done = 0;
        for (int y = 0; y < H; y += step) begin
            for (int x = 0; x < W; x += step) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    logic [15:0] fs[18];
                    logic [15:0] ws[18];
                    int acc = 0;
                    int t = 0;
                    if (done == limit) return;
                    if (done == pulse_at) begin
                        @(negedge clk);
                        start = 1'b1; mode = ~s;
                        @(negedge clk);
                        start = 1'b0; mode = s;
                    end
                    for (int ky = 0; ky < 3; ky++) begin
                        for (int kx = 0; kx < 3; kx++) begin
                            for (int ci = 0; ci < 2; ci++) begin
                                int iy = y + ky - 1;
                                int ix = x + kx - 1;
                                fs[t] = ones ? 16'd1 : 16'($urandom);
                                ws[t] = ones ? 16'd1 : 16'($urandom);
                                if (iy < 0 || iy >= H || ix < 0 || ix >= W) fs[t] = 16'd0;
                                acc += int'($signed(fs[t])) * int'($signed(ws[t]));
                                t++;
                            end
                        end
                    end
                    q.push_back('{x: x, y: y, ch: ch, val: 16'(acc)});
                    for (int k = 0; k < 18; k++) xfer(fs[k], ws[k]);
                    done++;
                end
            end
        end
    endtask

    task automatic finish_run(input int expn);
        @(negedge clk);
        check("final_output_valid", output_valid, 1);
        @(negedge clk);
        check("running_fell", running, 0);
        check("output_count", n_out, expn);
        check("queue_empty", q.size(), 0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int idle_bad;
        rst = 1'b1; start = 1'b0; mode = 1'b0; bus_valid = 1'b0; tb_drv = 1'b0;
        tb_f = '0; tb_w = '0; tb_b3 = '0;

        vecs[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0012};
        vecs[1] = '{16'h0001, 16'h0002, 1'b0, 16'h0024};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFEE};
        vecs[3] = '{16'h7FFF, 16'h0002, 1'b1, 16'hFFFE};
        vecs[4] = '{16'h0100, 16'h0100, 1'b0, 16'h0000};
        vecs[5] = '{16'hFFFD, 16'hFFFB, 1'b0, 16'h010E};
        vecs[6] = '{16'h1000, 16'h0004, 1'b0, 16'h8000};
        vecs[7] = '{16'h7FFF, 16'h7FFF, 1'b0, 16'h0012};

        repeat (3) @(negedge clk);
        check_reset_state("initial_reset");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            start_conv(1'b0);
            for (int t = 0; t < 18; t++) begin
                if (t == 0 || !vecs[i].first_only) xfer(vecs[i].f, vecs[i].w);
                else                               xfer(16'd0, 16'd0);
            end
            @(negedge clk);
            check("vec_valid", output_valid, 1);
            check("vec_value", bus_1, vecs[i].exp);
            check("vec_coord", {output_x, output_y, output_ch}, 0);
            do_reset();
        end

        // Full stride-1 run with random data and random bus_valid gaps.
        mon_en = 1'b1;
        q.delete(); n_out = 0;
        start_conv(1'b0);
        run_conv(1'b0, 1 << 30, 1'b0, -1);
        finish_run(W * H * NCH);

        // Abort after 100 outputs mid-operation.
        q.delete(); n_out = 0;
        start_conv(1'b0);
        run_conv(1'b0, 100, 1'b1, -1);
        for (int k = 0; k < 5; k++) xfer(16'd1, 16'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("abort_reset_state");
        check("abort_output_count", n_out, 100);
        @(negedge clk);
        rst = 1'b0;
        idle_bad = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            tb_drv = 1'b1; bus_valid = 1'b1; tb_f = 16'd1; tb_w = 16'd1;
            if (output_valid || bus_ready || running) idle_bad++;
        end
        bus_valid = 1'b0; tb_drv = 1'b0;
        check("idle_after_abort", idle_bad, 0);

        // Stride-2 restart from (0,0,0) with an ignored start pulse mid-run.
        q.delete(); n_out = 0;
        start_conv(1'b1);
        run_conv(1'b1, 1 << 30, 1'b0, 10);
        finish_run((W / 2) * (H / 2) * NCH);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/top_system.md
TOP_SYSTEM -- requirements
Module: top_system

Interface
REQ-001 Parameters: IO_DATA_WIDTH=16, bus word width; ACCUMULATION_WIDTH=16, accumulator width; FEATURE_MAP_WIDTH=128 and FEATURE_MAP_HEIGHT=128, input map size; INPUT_NB_CHANNELS=2; OUTPUT_NB_CHANNELS=16; kernel size fixed at 3 (local constant).
REQ-002 Timing: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, all logic on rising edge.
REQ-004 arst_n_in  in  1  reset, synchronous, active-high (asserted = 1).
REQ-005 conv_stride_mode  in  1  0 = stride 1, 1 = stride 2; sampled when start is accepted.
REQ-006 bus_1, bus_2, bus_3  inout  IO_DATA_WIDTH each  data busses, testbench-driven except during output cycles.
REQ-007 bus_valid  in  1  testbench offers a word on the busses.
REQ-008 bus_ready  out  1  DUT accepts a word this cycle.
REQ-009 driving_busses  out  1  DUT is driving the busses this cycle.
REQ-010 output_valid  out  1  result on bus_1 valid this cycle.
REQ-011 output_x, output_y  out  $clog2(FEATURE_MAP_WIDTH) and $clog2(FEATURE_MAP_HEIGHT) bits  input-space coordinate of the kernel centre.
REQ-012 output_ch  out  $clog2(OUTPUT_NB_CHANNELS)  output channel of the result.
REQ-013 start  in  1  single-cycle request to begin one full convolution.
REQ-014 running  out  1  high while a convolution is in progress.

Function
REQ-015 FSM states: IDLE, FETCH, OUTPUT.
REQ-016 IDLE: start=1 -> FETCH next cycle; latch stride (1 or 2); clear the accumulator and all counters; running=1 from that next cycle.
REQ-017 Loop order, outermost first: y (0..H-1 step stride), x (0..W-1 step stride), output channel (0..15); inner loops: ky (0..2), kx (0..2), input channel (0..1). This gives 18 transfers per output.
REQ-018 FETCH: bus_ready=1. A transfer occurs at a rising edge with bus_valid=1 and bus_ready=1. bus_1 carries the feature value and bus_2 the weight, both signed two's complement. bus_3 is ignored.
REQ-019 The testbench supplies zero for padded (out-of-map) positions; the DUT does no padding.
REQ-020 MAC per transfer: signed 32-bit product, low ACCUMULATION_WIDTH bits added to the accumulator, wrap on overflow with no saturation.
REQ-021 After the 18th transfer -> OUTPUT for exactly one cycle.
REQ-022 OUTPUT cycle: output_valid=1, driving_busses=1, bus_1 = accumulator sign-extended or truncated to IO_DATA_WIDTH, bus_2 and bus_3 driven 0, bus_ready=0, output_x/y/ch = current loop values.
REQ-023 After OUTPUT: clear the accumulator; return to FETCH, or to IDLE after the final output (x=W-stride, y=H-stride, ch=15), with running=0 the cycle after that final output.
REQ-024 Outside OUTPUT: the DUT drives all three busses high-Z and holds driving_busses=0 and output_valid=0.
REQ-025 start is ignored while running=1.
REQ-026 bus_valid low during FETCH: hold all state, no accumulation.
REQ-027 Output count: 128*128*16 for stride 1; 64*64*16 for stride 2 (coordinates are even values 0..126).

Reset
REQ-028 arst_n_in=1 at a clock edge -> IDLE; bus_ready, driving_busses, output_valid, running, output_x/y/ch and accumulator = 0; busses high-Z.
REQ-029 Reset mid-operation aborts immediately with no further outputs; a new start after reset begins from (0,0,ch0).

Structure
REQ-030 Shared package holds the kernel-size constant, the FSM state enum and default parameter values.
REQ-031 One sub-module, mac_unit: multiplier plus accumulator adder, with ports for feature, weight, accumulate-enable and clear.
REQ-032 All datapath multiplication and addition sit inside mac_unit; counters may use plain increment.

Verification
REQ-033 All features=1, weights=1, stride 0 -> every output = 18; first output at x=0,y=0,ch=0; 262144 outputs in total.
REQ-034 Stride mode 1, all features=1, weights=2 -> every output = 36; last output at x=126,y=126,ch=15; 65536 outputs; running falls the next cycle.
REQ-035 Feature 0x7FFF, weight 2 on the first transfer, zeros otherwise -> result 0xFFFE (wrap).
REQ-036 Random bus_valid gaps of 0-3 cycles with random signed data -> results match a software model; no transfer while bus_valid=0.
REQ-037 Reset asserted after 100 outputs -> all outputs 0 and busses Z next cycle; restart produces the first output at (0,0,0) with the correct value.
REQ-038 start pulsed while running -> no effect; output sequence unchanged.
